vga_scan_controller: RTL and testbench

Generates 640x480@60 Hz VGA scan timing and drives the linear pixel address into the game renderer. It then samples the renderer's 24-bit colour after a fixed pipeline latency and presents RGB together with sync and blank signals to the VGA DAC. It is the consumer end of the renderer's address-in / pixel-out interface. The renderer's per-frame timers and the game logic's frame update rely on this block's address sequence and frame strobes.

---
 rtl/vga_scan_controller.sv | 131 +++++++++++++
 tb/tb_vga_scan_controller.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_scan_controller.sv
// vga_scan_controller: 640x480@60 VGA scan timing generator and renderer consumer.
// Walks the (h,v) raster, drives the linear pixel address to the renderer,
// and delays sync/blank flags to line up with the renderer's colour reply.
// Ports:
//   iClock       pixel clock (sole clock)
//   iResetN      asynchronous active-low reset
//   iPixel       renderer colour {R,G,B}, PIXEL_LATENCY cycles after oAddress
//   oAddress     linear pixel address y*H_ACTIVE+x (undelayed)
//   oFrameStart  one-cycle pulse when the counters wrap to (0,0) (undelayed)
//   oVBlank      high while v >= V_ACTIVE (undelayed)
//   oHSync       active-low hsync, delayed PIXEL_LATENCY+1 cycles
//   oVSync       active-low vsync, delayed PIXEL_LATENCY+1 cycles
//   oBlankN      high on visible pixels, delayed PIXEL_LATENCY+1 cycles
//   oRed/oGreen/oBlue  DAC colour, forced to zero outside the visible area
module vga_scan_controller #(
   parameter int unsigned H_ACTIVE      = 640,
   parameter int unsigned H_FP          = 16,
   parameter int unsigned H_SYNC        = 96,
   parameter int unsigned H_BP          = 48,
   parameter int unsigned V_ACTIVE      = 480,
   parameter int unsigned V_FP          = 10,
   parameter int unsigned V_SYNC        = 2,
   parameter int unsigned V_BP          = 33,
   parameter int unsigned PIXEL_LATENCY = 3
) (
   input  logic        iClock,
   input  logic        iResetN,
   input  logic [23:0] iPixel,
   output logic [18:0] oAddress,
   output logic        oFrameStart,
   output logic        oVBlank,
   output logic        oHSync,
   output logic        oVSync,
   output logic        oBlankN,
   output logic [7:0]  oRed,
   output logic [7:0]  oGreen,
   output logic [7:0]  oBlue
);

   localparam int unsigned CNT_W     = 10;
   localparam int unsigned ADDR_W    = 19;
   localparam int unsigned DLY       = PIXEL_LATENCY + 1;
   localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END    = HS_START + H_SYNC - 1;
   localparam int unsigned VS_START  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END    = VS_START + V_SYNC - 1;

   logic [CNT_W-1:0]  h_q, h_d, v_q, v_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              fs_q, fs_d, vb_q, vb_d;
   logic              h_wrap_c, v_wrap_c, frame_wrap_c, next_active_c;
   logic              act_c, hs_c, vs_c;
   logic [DLY-1:0]    act_dly_q, hs_dly_q, vs_dly_q;
   logic [23:0]       rgb_q;

   // Next raster position; address is computed for the position being entered
   // so oAddress always matches the counters in the same cycle.
   always_comb begin
      h_wrap_c      = (h_q == CNT_W'(H_TOTAL - 1));
      v_wrap_c      = (v_q == CNT_W'(V_TOTAL - 1));
      frame_wrap_c  = h_wrap_c && v_wrap_c;
      h_d           = h_wrap_c ? '0 : h_q + CNT_W'(1);
      v_d           = v_q;
      if (h_wrap_c) begin
         v_d = v_wrap_c ? '0 : v_q + CNT_W'(1);
      end
      next_active_c = (h_d < CNT_W'(H_ACTIVE)) && (v_d < CNT_W'(V_ACTIVE));
      // Incremental address: hold through blanking, step on each visible pixel.
      addr_d = addr_q;
      if (frame_wrap_c) begin
         addr_d = '0;
      end else if (next_active_c) begin
         addr_d = addr_q + ADDR_W'(1);
      end
      fs_d = frame_wrap_c;
      vb_d = (v_d >= CNT_W'(V_ACTIVE));
   end

   // Flags of the current position, entering the delay line.
   always_comb begin
      act_c = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
      hs_c  = !((h_q >= CNT_W'(HS_START)) && (h_q <= CNT_W'(HS_END)));
      vs_c  = !((v_q >= CNT_W'(VS_START)) && (v_q <= CNT_W'(VS_END)));
   end

   // Raster counters and undelayed outputs.
   always_ff @(posedge iClock or negedge iResetN) begin
      if (!iResetN) begin
         h_q    <= '0;
         v_q    <= '0;
         addr_q <= '0;
         fs_q   <= 1'b0;
         vb_q   <= 1'b0;
      end else begin
         h_q    <= h_d;
         v_q    <= v_d;
         addr_q <= addr_d;
         fs_q   <= fs_d;
         vb_q   <= vb_d;
      end
   end

   // Delay line; colour is captured on the edge that loads the last stage,
   // so it is gated by the stage just before it.
   always_ff @(posedge iClock or negedge iResetN) begin
      if (!iResetN) begin
         act_dly_q <= '0;
         hs_dly_q  <= '1;
         vs_dly_q  <= '1;
         rgb_q     <= '0;
      end else begin
         act_dly_q <= {act_dly_q[DLY-2:0], act_c};
         hs_dly_q  <= {hs_dly_q[DLY-2:0], hs_c};
         vs_dly_q  <= {vs_dly_q[DLY-2:0], vs_c};
         rgb_q     <= act_dly_q[DLY-2] ? iPixel : 24'h000000;
      end
   end

   assign oAddress    = addr_q;
   assign oFrameStart = fs_q;
   assign oVBlank     = vb_q;
   assign oHSync      = hs_dly_q[DLY-1];
   assign oVSync      = vs_dly_q[DLY-1];
   assign oBlankN     = act_dly_q[DLY-1];
   assign oRed        = rgb_q[23:16];
   assign oGreen      = rgb_q[15:8];
   assign oBlue       = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_controller.sv
// Scoreboard bench for vga_scan_controller. Horizontal timing is the full
// 640-pixel line; the vertical total is shortened to 8 lines (4 visible,
// fp 1, sync 2, bp 1) so that two whole frames fit in a short run.
// Frame = 6400 cycles; cycle 0 is the first cycle after reset release.
module tb_vga_scan_controller;

   logic        iClock = 1'b0;
   logic        iResetN = 1'b0;
   logic [23:0] iPixel;
   logic [18:0] oAddress;
   logic        oFrameStart, oVBlank, oHSync, oVSync, oBlankN;
   logic [7:0]  oRed, oGreen, oBlue;

   vga_scan_controller #(
      .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .PIXEL_LATENCY(3)
   ) dut (
      .iClock(iClock), .iResetN(iResetN), .iPixel(iPixel),
      .oAddress(oAddress), .oFrameStart(oFrameStart), .oVBlank(oVBlank),
      .oHSync(oHSync), .oVSync(oVSync), .oBlankN(oBlankN),
      .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue)
   );

   always #5 iClock = ~iClock;

   typedef struct {
      int unsigned c0;
      int unsigned c1;
      int unsigned fld;
      logic [23:0] val;
   } vec_t;

   vec_t        exp_q[$];
   vec_t        rst_q[$];
   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic        const_mode = 1'b0;
   logic [18:0] d1 = '0, d2 = '0, d3 = '0;
   string       names [7] = '{"addr", "frame_start", "vblank", "hsync",
                              "vsync", "blank_n", "rgb"};

   // Renderer stub: colour = address seen three cycles earlier.
   always @(posedge iClock) begin
      d1 <= oAddress;
      d2 <= d1;
      d3 <= d2;
   end
   assign iPixel = const_mode ? 24'hFF8000 : {5'b0, d3};

   function automatic logic [23:0] act_val(input int unsigned f);
      case (f)
         0: act_val = {5'b0, oAddress};
         1: act_val = {23'b0, oFrameStart};
         2: act_val = {23'b0, oVBlank};
         3: act_val = {23'b0, oHSync};
         4: act_val = {23'b0, oVSync};
         5: act_val = {23'b0, oBlankN};
         default: act_val = {oRed, oGreen, oBlue};
      endcase
   endfunction

   task automatic check(input vec_t e, input int unsigned c);
      logic [23:0] a;
      a = act_val(e.fld);
      total++;
      if (a !== e.val) begin
         bad++;
         $display("FAIL %s cycle=%0d actual=%h required=%h", names[e.fld], c, a, e.val);
      end
   endtask

   task automatic push(input int unsigned c0, input int unsigned c1,
                       input int unsigned f, input logic [23:0] v);
      vec_t e;
      e.c0 = c0; e.c1 = c1; e.fld = f; e.val = v;
      exp_q.push_back(e);
   endtask

   task automatic push_rst(input int unsigned f, input logic [23:0] v);
      vec_t e;
      e.c0 = 0; e.c1 = 0; e.fld = f; e.val = v;
      rst_q.push_back(e);
   endtask

   // Monitor: sample away from the active edge, compare every live vector,
   // retire vectors whose window has closed.
   always @(negedge iClock) begin
      if (!iResetN) begin
         while (rst_q.size() > 0) check(rst_q.pop_front(), 0);
         cyc <= 0;
      end else begin
         for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].c0 <= cyc && cyc <= exp_q[i].c1) check(exp_q[i], cyc);
            if (cyc >= exp_q[i].c1) exp_q.delete(i);
         end
         cyc <= cyc + 1;
      end
   end

   initial begin
      // Precondition: run into the middle of line 0, then reset mid-line.
      repeat (3) @(posedge iClock);
      #1 iResetN = 1'b1;
      repeat (300) @(posedge iClock);

      push_rst(0, 24'h0); push_rst(1, 24'h0); push_rst(2, 24'h0);
      push_rst(3, 24'h1); push_rst(4, 24'h1); push_rst(5, 24'h0);
      push_rst(6, 24'h0);
      #2 iResetN = 1'b0;

      // address sequence
      push(0, 0, 0, 24'd0);
      push(1, 1, 0, 24'd1);
      push(639, 799, 0, 24'd639);
      push(800, 800, 0, 24'd640);
      push(3039, 6399, 0, 24'd2559);
      push(6400, 6400, 0, 24'd0);
      // frame strobe: none until the first wrap, then every 6400 cycles
      push(0, 6399, 1, 24'h0);
      push(6400, 6400, 1, 24'h1);
      push(6401, 12799, 1, 24'h0);
      push(12800, 12800, 1, 24'h1);
      // vblank (undelayed)
      push(0, 3199, 2, 24'h0);
      push(3200, 6399, 2, 24'h1);
      push(6400, 9599, 2, 24'h0);
      // hsync
      push(0, 659, 3, 24'h1);
      push(660, 755, 3, 24'h0);
      push(756, 1459, 3, 24'h1);
      push(1460, 1460, 3, 24'h0);
      // vsync: 1600 cycles low per frame
      push(0, 4003, 4, 24'h1);
      push(4004, 5603, 4, 24'h0);
      push(5604, 10403, 4, 24'h1);
      push(10404, 10404, 4, 24'h0);
      // blank_n
      push(0, 3, 5, 24'h0);
      push(4, 643, 5, 24'h1);
      push(644, 803, 5, 24'h0);
      push(804, 804, 5, 24'h1);
      // colour latency with address stub
      push(0, 3, 6, 24'h000000);
      push(4, 4, 6, 24'h000000);
      push(5, 5, 6, 24'h000001);
      push(804, 804, 6, 24'h000280);
      // blank forcing with constant colour (from cycle 1000)
      push(1604, 2243, 6, 24'hFF8000);
      push(2244, 2403, 6, 24'h000000);
      push(3204, 6403, 6, 24'h000000);
      push(6404, 7043, 6, 24'hFF8000);

      repeat (3) @(posedge iClock);
      #1 iResetN = 1'b1;
      repeat (1000) @(posedge iClock);
      #1 const_mode = 1'b1;
      repeat (11820) @(posedge iClock);
      @(negedge iClock);
      #1;
      while (exp_q.size() > 0) begin
         vec_t e;
         e = exp_q.pop_front();
         total++;
         bad++;
         $display("FAIL %s window=%0d..%0d never reached (last cycle %0d)",
                  names[e.fld], e.c0, e.c1, cyc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
